pc_sequencer: RTL

//  Next-PC controller for the MIPS fetch stage. Drives PC.dataInput with pc_next and reads PC.dataOut as pc_cur.

---
 rtl/pc_sequencer.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC controller for the MIPS fetch stage.
// Chooses the value loaded into the PC register on every falling clock edge.
// The choices are an exception, a jump, a taken branch, or PC+4. It also
// handles stalls, a pending redirect, halt/resume, and flushing IF/ID.
// The PC register has no enable. To hold, this block feeds pc_cur back on pc_next.
// Optional feature: define PCSEQ_EXC_EN to add the exc_req port and exception
// redirects to EXC_VECTOR. The default build has no exception logic.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0180,
    parameter int          CNT_W        = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [31:0]      pc_cur,
    input  logic             stall,
    input  logic             br_taken,
    input  logic [31:0]      br_target,
    input  logic             jmp_valid,
    input  logic [31:0]      jmp_target,
    input  logic             halt_req,
    input  logic             resume,
`ifdef PCSEQ_EXC_EN
    input  logic             exc_req,
`endif
    output logic [31:0]      pc_next,
    output logic             fetch_valid,
    output logic             flush,
    output logic             misalign,
    output logic [1:0]       seq_state,
    output logic [CNT_W-1:0] redirect_cnt
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_PEND  = 2'b10,
        ST_HALT  = 2'b11
    } state_t;

    // Redirect priority levels. Higher values win. A pending redirect remembers its level.
    localparam logic [1:0] PRI_NONE = 2'd0;
    localparam logic [1:0] PRI_BR   = 2'd1;
    localparam logic [1:0] PRI_JMP  = 2'd2;
    localparam logic [1:0] PRI_EXC  = 2'd3;

    state_t             state_q, state_d;
    logic [31:0]        pend_q, pend_d;
    logic [1:0]         pend_pri_q, pend_pri_d;
    logic               flush_q, flush_d;
    logic               fetch_valid_q, fetch_valid_d;
    logic               misalign_q, misalign_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               first_q, first_d;

    logic [1:0]         req_pri;
    logic [31:0]        req_raw;
    logic [31:0]        req_tgt;
    logic               req_mis;

    logic               do_apply;
    logic               do_capture;
    logic               take_new;
    logic [31:0]        sel_tgt;

`ifndef PCSEQ_EXC_EN
    // The exception vector only matters when the exception feature is built in.
    logic               unused_exc_vector;
    assign unused_exc_vector = ^EXC_VECTOR;
`endif

    // Pick the highest-priority redirect request that is active this cycle.
    always_comb begin
        req_pri = PRI_NONE;
        req_raw = 32'h0000_0000;
        if (br_taken) begin
            req_pri = PRI_BR;
            req_raw = br_target;
        end
        if (jmp_valid) begin
            req_pri = PRI_JMP;
            req_raw = jmp_target;
        end
`ifdef PCSEQ_EXC_EN
        if (exc_req) begin
            req_pri = PRI_EXC;
            req_raw = EXC_VECTOR;
        end
`endif
        // Fetch is word-aligned, so the low two target bits are dropped.
        // A nonzero value in those bits is reported through misalign.
        req_tgt = {req_raw[31:2], 2'b00};
        req_mis = |req_raw[1:0];
    end

    // Sequencer next-state logic and pc_next selection.
    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        pend_pri_d = pend_pri_q;
        flush_d    = 1'b0;
        misalign_d = misalign_q;
        cnt_d      = cnt_q;
        first_d    = 1'b0;
        pc_next    = pc_cur;
        do_apply   = 1'b0;
        do_capture = 1'b0;
        take_new   = 1'b0;
        sel_tgt    = req_tgt;

        if (first_q) begin
            // first_q is set asynchronously while RST_N is low.
            // This drives the reset vector during reset and on the first edge after release.
            pc_next = RESET_VECTOR;
            state_d = ST_RUN;
        end else if (halt_req) begin
            // Halt outranks everything, including exceptions. Any pending target is dropped.
            state_d    = ST_HALT;
            pend_pri_d = PRI_NONE;
        end else if (req_pri == PRI_EXC) begin
            // Exceptions never wait: they ignore stall, pending redirects and HALT.
            do_apply = 1'b1;
            take_new = 1'b1;
        end else begin
            unique case (state_q)
                ST_RUN, ST_STALL: begin
                    if (req_pri != PRI_NONE) begin
                        take_new = 1'b1;
                        if (stall) do_capture = 1'b1;
                        else       do_apply   = 1'b1;
                    end else if (stall) begin
                        state_d = ST_STALL;
                    end else begin
                        pc_next = pc_cur + 32'd4;
                        state_d = ST_RUN;
                    end
                end
                ST_PEND: begin
                    // A new request replaces the pending one only if its priority is equal or higher.
                    if (req_pri != PRI_NONE && req_pri >= pend_pri_q) take_new = 1'b1;
                    if (stall) begin
                        do_capture = take_new;
                    end else begin
                        do_apply = 1'b1;
                        if (!take_new) sel_tgt = pend_q;
                    end
                end
                ST_HALT: begin
                    if (resume) begin
                        pc_next = pc_cur + 32'd4;
                        state_d = ST_RUN;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end

        if (do_apply) begin
            pc_next    = sel_tgt;
            flush_d    = 1'b1;
            cnt_d      = cnt_q + CNT_W'(1);
            state_d    = ST_RUN;
            pend_pri_d = PRI_NONE;
        end
        if (do_capture) begin
            pend_d     = req_tgt;
            pend_pri_d = req_pri;
            state_d    = ST_PEND;
        end
        if (take_new) misalign_d = misalign_q | req_mis;

        // The instruction fetched on the edge after a redirect is squashed. Nothing is valid while halted.
        fetch_valid_d = !flush_d && (state_d != ST_HALT);
    end

    // State registers update on the falling edge, the same edge that loads the PC register.
    always_ff @(negedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q       <= ST_RUN;
            pend_q        <= 32'h0000_0000;
            pend_pri_q    <= PRI_NONE;
            flush_q       <= 1'b0;
            fetch_valid_q <= 1'b0;
            misalign_q    <= 1'b0;
            cnt_q         <= '0;
            first_q       <= 1'b1;
        end else begin
            state_q       <= state_d;
            pend_q        <= pend_d;
            pend_pri_q    <= pend_pri_d;
            flush_q       <= flush_d;
            fetch_valid_q <= fetch_valid_d;
            misalign_q    <= misalign_d;
            cnt_q         <= cnt_d;
            first_q       <= first_d;
        end
    end

    assign fetch_valid  = fetch_valid_q;
    assign flush        = flush_q;
    assign misalign     = misalign_q;
    assign seq_state    = state_q;
    assign redirect_cnt = cnt_q;

endmodule
